// File: rtl/result_drain_arbiter.sv
// result_drain_arbiter: round-robin drain of three per-port result RAMs into one valid/ready stream tagged with the source port.
// Latency: grant registered in IDLE, rden during ISSUE, RAM data captured at the end of CAPTURE -> out_valid 3 edges after pending is seen.
// Backpressure: HOLD keeps out_valid/out_data/out_port stable until out_ready; no further RAM reads are issued while a word is held.
//
// Ports:
//   clk, reset                  clock and asynchronous active-high reset
//   wrcount1..3                 writer-side write counts (free-running, wrapping)
//   ramdata1..3                 RAM q outputs, valid the cycle after rden
//   en_mask                     per-port drain enable, bit0 = port 1
//   rdaddr1..3, rden1..3        RAM read address (= read counter) and one-hot read enable
//   out_valid/out_data/out_port drained word stream, out_ready from the consumer
//   busy                        high whenever a transaction is in progress

module result_drain_arbiter #(
    parameter int DEPTH_BITS = 14,
    parameter int DATA_W     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DEPTH_BITS-1:0] wrcount1,
    input  logic [DEPTH_BITS-1:0] wrcount2,
    input  logic [DEPTH_BITS-1:0] wrcount3,
    input  logic [DATA_W-1:0]     ramdata1,
    input  logic [DATA_W-1:0]     ramdata2,
    input  logic [DATA_W-1:0]     ramdata3,
    input  logic [2:0]            en_mask,
    output logic [DEPTH_BITS-1:0] rdaddr1,
    output logic [DEPTH_BITS-1:0] rdaddr2,
    output logic [DEPTH_BITS-1:0] rdaddr3,
    output logic                  rden1,
    output logic                  rden2,
    output logic                  rden3,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic [1:0]            out_port,
    input  logic                  out_ready,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t                state;
    state_t                state_nxt;

    logic [1:0]            grant;      // port being served, 1..3
    logic [1:0]            rr;         // first port searched on the next arbitration, 1..3
    logic [1:0]            winner;
    logic [1:0]            cand;
    logic                  win_vld;
    logic [3:0]            pending;    // indexed by port number; bit 0 never set
    logic [DEPTH_BITS-1:0] rdcount [1:3];
    logic [DEPTH_BITS-1:0] wrcount [1:3];
    logic [DATA_W-1:0]     ramdata_sel;

    // Port successor in the 1 -> 2 -> 3 -> 1 ring.
    function automatic logic [1:0] next_port(input logic [1:0] p);
        return (p == 2'd3) ? 2'd1 : p + 2'd1;
    endfunction

    assign wrcount[1] = wrcount1;
    assign wrcount[2] = wrcount2;
    assign wrcount[3] = wrcount3;

    // Plain inequality: both counters wrap at the same modulus, so the
    // wrap point needs no special handling. Full is the writer's problem.
    assign pending[0] = 1'b0;
    assign pending[1] = en_mask[0] && (rdcount[1] != wrcount[1]);
    assign pending[2] = en_mask[1] && (rdcount[2] != wrcount[2]);
    assign pending[3] = en_mask[2] && (rdcount[3] != wrcount[3]);

    // Round-robin search starting at rr; first pending port wins.
    always_comb begin
        winner  = 2'd0;
        win_vld = 1'b0;
        cand    = rr;
        for (int k = 0; k < 3; k++) begin
            if (!win_vld && pending[cand]) begin
                winner  = cand;
                win_vld = 1'b1;
            end
            cand = next_port(cand);
        end
    end

    // Next-state logic. Pending is only looked at in IDLE, so input
    // changes while busy cannot disturb the transaction in flight.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_vld) state_nxt = ISSUE;
            ISSUE:   state_nxt = CAPTURE;
            CAPTURE: state_nxt = HOLD;
            HOLD:    if (out_valid && out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Data returned by the RAM of the granted port.
    always_comb begin
        ramdata_sel = '0;
        case (grant)
            2'd1:    ramdata_sel = ramdata1;
            2'd2:    ramdata_sel = ramdata2;
            2'd3:    ramdata_sel = ramdata3;
            default: ramdata_sel = '0;
        endcase
    end

    // Datapath. The read counter advances at capture rather than at
    // acceptance: the RAM word is already in out_data, so it is never
    // re-read however long the consumer stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant     <= 2'd0;
            rr        <= 2'd1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_port  <= 2'd0;
            for (int i = 1; i <= 3; i++) begin
                rdcount[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        grant <= winner;
                    end
                end
                CAPTURE: begin
                    out_data  <= ramdata_sel;
                    out_port  <= grant;
                    out_valid <= 1'b1;
                    for (int i = 1; i <= 3; i++) begin
                        if (grant == 2'(i)) begin
                            rdcount[i] <= rdcount[i] + DEPTH_BITS'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        rr        <= next_port(grant);
                    end
                end
                default: ;
            endcase
        end
    end

    // RAM addresses follow the read counters at all times; the RAM samples
    // rdaddr on the same edge that samples rden (end of ISSUE).
    assign rdaddr1 = rdcount[1];
    assign rdaddr2 = rdcount[2];
    assign rdaddr3 = rdcount[3];

    assign rden1 = (state == ISSUE) && (grant == 2'd1);
    assign rden2 = (state == ISSUE) && (grant == 2'd2);
    assign rden3 = (state == ISSUE) && (grant == 2'd3);

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_result_drain_arbiter.sv
// tb_result_drain_arbiter: directed plus randomized stimulus for result_drain_arbiter.
// A transaction-level reference model (per-port pointers, rr pointer, edge count since grant) predicts every output each cycle.
// Three behavioural RAMs with one-cycle read latency feed ramdata1..3.

module tb_result_drain_arbiter;

    localparam int DB    = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << DB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DB-1:0] wr [1:3];
    logic [DW-1:0] rq [1:3];
    logic [2:0]    en_mask = 3'b111;
    logic          out_ready = 1'b1;

    logic [DB-1:0] rdaddr1, rdaddr2, rdaddr3;
    logic          rden1, rden2, rden3;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    out_port;
    logic          busy;

    always #5 clk = ~clk;

    result_drain_arbiter #(.DEPTH_BITS(DB), .DATA_W(DW)) dut (
        .clk(clk), .reset(rst),
        .wrcount1(wr[1]), .wrcount2(wr[2]), .wrcount3(wr[3]),
        .ramdata1(rq[1]), .ramdata2(rq[2]), .ramdata3(rq[3]),
        .en_mask(en_mask),
        .rdaddr1(rdaddr1), .rdaddr2(rdaddr2), .rdaddr3(rdaddr3),
        .rden1(rden1), .rden2(rden2), .rden3(rden3),
        .out_valid(out_valid), .out_data(out_data), .out_port(out_port),
        .out_ready(out_ready), .busy(busy)
    );

    // RAM contents and behavioural RAMs (address and rden sampled on the same edge).
    logic [DW-1:0] mem [1:3][0:DEPTH-1];

    always @(posedge clk) begin
        if (rden1) rq[1] <= mem[1][rdaddr1];
        if (rden2) rq[2] <= mem[2][rdaddr2];
        if (rden3) rq[3] <= mem[3][rdaddr3];
    end

    // Reference model.
    logic [DB-1:0] mrd [1:3];
    int            mrr   = 1;
    int            mg    = 0;
    int            mage  = 0;
    bit            mbusy = 0;
    bit            mvalid = 0;
    logic [DW-1:0] mdata = '0;
    int            mport = 0;

    function automatic bit m_pending(input int p);
        return en_mask[p-1] && (mrd[p] != wr[p]);
    endfunction

    function automatic int m_pick();
        for (int k = 0; k < 3; k++) begin
            if (m_pending((mrr - 1 + k) % 3 + 1)) return (mrr - 1 + k) % 3 + 1;
        end
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mrd[1] <= '0; mrd[2] <= '0; mrd[3] <= '0;
            mrr <= 1; mg <= 0; mage <= 0; mbusy <= 0;
            mvalid <= 0; mdata <= '0; mport <= 0;
        end else if (!mbusy) begin
            if (m_pick() != 0) begin
                mbusy <= 1;
                mg    <= m_pick();
                mage  <= 0;
            end
        end else begin
            mage <= mage + 1;
            if (mage == 1) begin
                mvalid  <= 1;
                mdata   <= mem[mg][mrd[mg]];
                mport   <= mg;
                mrd[mg] <= mrd[mg] + DB'(1);
            end else if (mage >= 2 && out_ready) begin
                mvalid <= 0;
                mrr    <= mg % 3 + 1;
                mbusy  <= 0;
            end
        end
    end

    // Accepted transfers, recorded on the edge where the handshake happens.
    int            xp [$];
    logic [DW-1:0] xd [$];
    int            xt [$];
    int            ncyc = 0;

    always @(posedge clk) begin
        ncyc <= ncyc + 1;
        if (!rst && out_valid && out_ready) begin
            xp.push_back(int'(out_port));
            xd.push_back(out_data);
            xt.push_back(ncyc);
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("rdaddr1", 32'(rdaddr1), 32'(mrd[1]));
        chk("rdaddr2", 32'(rdaddr2), 32'(mrd[2]));
        chk("rdaddr3", 32'(rdaddr3), 32'(mrd[3]));
        chk("rden1", 32'(rden1), 32'(mbusy && mage == 0 && mg == 1));
        chk("rden2", 32'(rden2), 32'(mbusy && mage == 0 && mg == 2));
        chk("rden3", 32'(rden3), 32'(mbusy && mage == 0 && mg == 3));
        chk("out_valid", 32'(out_valid), 32'(mvalid));
        chk("out_data", 32'(out_data), 32'(mdata));
        chk("out_port", 32'(out_port), 32'(mport));
        chk("busy", 32'(busy), 32'(mbusy));
    endtask

    // One clock: sample on the falling edge, compare with the model.
    task automatic cyc();
        @(negedge clk);
        check_all();
    endtask

    task automatic wait_valid(input string tag, input int bound);
        for (int i = 0; i < bound && !out_valid; i++) cyc();
        chk(tag, 32'(out_valid), 32'd1);
    endtask

    function automatic int qp(input int i);
        return (i < xp.size()) ? xp[i] : 99;
    endfunction

    logic [DW-1:0] hd, hold_data;
    logic [1:0]    hold_port;
    logic [DB-1:0] hold_addr;
    int            p, n0;

    initial begin
        for (int q = 1; q <= 3; q++) begin
            wr[q] = '0;
            rq[q] = '0;
            for (int a = 0; a < DEPTH; a++) mem[q][a] = DW'($urandom);
        end
        mem[1][0] = 8'hA5;

        // Reset state
        repeat (2) cyc();
        chk("rst_out_port", 32'(out_port), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (2) cyc();

        // Single word from port 1
        wr[1] = 1;
        cyc();
        chk("sw_rden1", 32'(rden1), 32'd1);
        chk("sw_addr", 32'(rdaddr1), 32'd0);
        cyc();
        chk("sw_rden1_off", 32'(rden1), 32'd0);
        chk("sw_valid_early", 32'(out_valid), 32'd0);
        cyc();
        chk("sw_valid", 32'(out_valid), 32'd1);
        chk("sw_data", 32'(out_data), 32'hA5);
        chk("sw_port", 32'(out_port), 32'd1);
        cyc();
        chk("sw_done_valid", 32'(out_valid), 32'd0);
        chk("sw_done_addr", 32'(rdaddr1), 32'd1);
        chk("sw_done_busy", 32'(busy), 32'd0);

        // Fairness: three words on every port from a fresh reset
        rst = 1'b1;
        wr[1] = 0; wr[2] = 0; wr[3] = 0;
        cyc();
        rst = 1'b0;
        xp.delete(); xd.delete(); xt.delete();
        wr[1] = 3; wr[2] = 3; wr[3] = 3;
        for (int i = 0; i < 80 && !(xp.size() == 9 && !busy); i++) cyc();
        chk("fair_count", 32'(xp.size()), 32'd9);
        for (int i = 0; i < 9; i++) chk("fair_port", 32'(qp(i)), 32'(i % 3 + 1));
        for (int i = 1; i < 9; i++)
            chk("fair_rate", 32'((i < xt.size()) ? xt[i] - xt[i-1] : 0), 32'd4);
        chk("fair_addr1", 32'(rdaddr1), 32'd3);
        chk("fair_addr2", 32'(rdaddr2), 32'd3);
        chk("fair_addr3", 32'(rdaddr3), 32'd3);

        // Backpressure: consumer stalls for 10 cycles
        out_ready = 1'b0;
        wr[1] = 4;
        wait_valid("bp_wait", 10);
        hold_data = out_data;
        hold_port = out_port;
        hold_addr = rdaddr1;
        n0 = xp.size();
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("bp_data", 32'(out_data), 32'(hold_data));
            chk("bp_port", 32'(out_port), 32'(hold_port));
            chk("bp_addr", 32'(rdaddr1), 32'(hold_addr));
            chk("bp_rden", 32'(rden1 | rden2 | rden3), 32'd0);
            chk("bp_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        cyc();
        chk("bp_release", 32'(out_valid), 32'd0);
        repeat (5) cyc();
        chk("bp_one_xfer", 32'(xp.size()), 32'(n0 + 1));

        // Counter wrap on port 2
        wr[2] = DB'(DEPTH - 1);
        for (int i = 0; i < DEPTH * 4 + 100 && !(rdaddr2 == DB'(DEPTH - 1) && !busy); i++) cyc();
        chk("wrap_preset", 32'(rdaddr2), 32'(DEPTH - 1));
        xp.delete(); xd.delete(); xt.delete();
        wr[2] = 1;
        repeat (20) cyc();
        chk("wrap_count", 32'(xp.size()), 32'd2);
        chk("wrap_port0", 32'(qp(0)), 32'd2);
        chk("wrap_port1", 32'(qp(1)), 32'd2);
        chk("wrap_data0", 32'((xd.size() > 0) ? xd[0] : 8'h00), 32'(mem[2][DEPTH-1]));
        chk("wrap_data1", 32'((xd.size() > 1) ? xd[1] : 8'h00), 32'(mem[2][0]));
        chk("wrap_addr", 32'(rdaddr2), 32'd1);
        chk("wrap_idle", 32'(busy), 32'd0);

        // Mask: ports 1 and 3 only, alternating (rr points at 3 after port 2)
        en_mask = 3'b101;
        wr[1] = wr[1] + DB'(4);
        wr[2] = wr[2] + DB'(4);
        wr[3] = wr[3] + DB'(4);
        xp.delete(); xd.delete(); xt.delete();
        for (int i = 0; i < 60 && xp.size() < 4; i++) cyc();
        chk("mask_p0", 32'(qp(0)), 32'd3);
        chk("mask_p1", 32'(qp(1)), 32'd1);
        chk("mask_p2", 32'(qp(2)), 32'd3);
        chk("mask_p3", 32'(qp(3)), 32'd1);
        for (int i = 0; i < 30 && !rden1; i++) cyc();
        chk("mask_rden1", 32'(rden1), 32'd1);
        xp.delete(); xd.delete(); xt.delete();
        cyc();
        en_mask = 3'b100;
        repeat (30) cyc();
        chk("mask_cnt", 32'(xp.size()), 32'd2);
        chk("mask_late1", 32'(qp(0)), 32'd1);
        chk("mask_only3", 32'(qp(1)), 32'd3);
        chk("mask_idle", 32'(busy), 32'd0);

        // Randomized traffic, mask changes and consumer stalls
        for (int i = 0; i < 1500; i++) begin
            p = $urandom_range(1, 3);
            if ($urandom_range(0, 2) == 0) begin
                hd = wr[p] - mrd[p];
                if (hd < 40) wr[p] = wr[p] + DB'($urandom_range(1, 3));
            end
            if ($urandom_range(0, 49) == 0) en_mask = 3'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        en_mask = 3'b111;
        out_ready = 1'b1;
        for (int i = 0; i < 1000 && !(wr[1] == rdaddr1 && wr[2] == rdaddr2 && wr[3] == rdaddr3 && !busy); i++) cyc();
        chk("rand_drained", 32'(busy), 32'd0);
        chk("rand_addr1", 32'(rdaddr1), 32'(wr[1]));
        chk("rand_addr2", 32'(rdaddr2), 32'(wr[2]));
        chk("rand_addr3", 32'(rdaddr3), 32'(wr[3]));

        // Asynchronous reset while a word is held
        out_ready = 1'b0;
        wr[2] = wr[2] + DB'(2);
        wait_valid("rst_wait_hold", 20);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_rden", 32'(rden1 | rden2 | rden3), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_addr2", 32'(rdaddr2), 32'd0);
        chk("arst_addr1", 32'(rdaddr1), 32'd0);
        wr[1] = 1; wr[2] = 1; wr[3] = 1;
        out_ready = 1'b1;
        cyc();
        rst = 1'b0;
        xp.delete(); xd.delete(); xt.delete();
        for (int i = 0; i < 40 && !(xp.size() == 3 && !busy); i++) cyc();
        chk("arst_restart0", 32'(qp(0)), 32'd1);
        chk("arst_restart1", 32'(qp(1)), 32'd2);
        chk("arst_restart2", 32'(qp(2)), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
